// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern display datapath.
//   state_e       : pattern scheduler FSM states
//   PAT_W_DEF     : default pattern index width
//   NUM_PAT_DEF   : default number of patterns
//   H_/V_ timing  : 640x480 VGA frame geometry (800x525 total)
//   cnt_w()       : counter width for a count limit, never below 1 bit
package pattern_pkg;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_AUTO   = 2'd1,
    ST_MANUAL = 2'd2
  } state_e;

  localparam int unsigned PAT_W_DEF   = 3;
  localparam int unsigned NUM_PAT_DEF = 8;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;

  function automatic int unsigned cnt_w(input int unsigned v);
    if (v <= 32'd1) return 32'd1;
    return $clog2(v);
  endfunction

endpackage

// File: rtl/pattern_frame_tick.sv
// Frame boundary detector: one-cycle tick when VSYNC enters its active level.
//   clk, rst_n : clock, async active-low reset
//   vsync      : vertical sync, synchronous to clk
//   tick_c     : combinational pulse, high in the first cycle vsync is active
module pattern_frame_tick #(
  parameter bit VS_POL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic tick_c
);

  logic vs_q;
  logic vs_d;

  assign vs_d = vsync;

  // Reset to the inactive level so a sync already active at release is a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= ~VS_POL;
    else        vs_q <= vs_d;
  end

  assign tick_c = (vsync == VS_POL) && (vs_q != VS_POL);

endmodule

// File: rtl/pattern_sched.sv
// Frame-synchronous test pattern scheduler.
//   CLK, RST_N : pixel clock, async active-low reset
//   VSYNC      : vertical sync (active level VS_POL)
//   NEXT, MODE : single-cycle advance / auto-manual toggle requests
//   PAUSE      : level, freezes the auto hold counter
//   PAT_SEL    : current pattern index
//   BLANK      : pattern generator drives black
//   PAT_CHG    : one-cycle pulse when PAT_SEL or BLANK changes
//   AUTO       : auto mode in effect
//   FRAME_CNT  : free-running frame counter
module pattern_sched
  import pattern_pkg::*;
#(
  parameter int unsigned NUM_PAT        = NUM_PAT_DEF,
  parameter int unsigned PAT_W          = PAT_W_DEF,
  parameter int unsigned HOLD_FRAMES    = 120,
  parameter int unsigned STARTUP_FRAMES = 4,
  parameter bit          VS_POL         = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             VSYNC,
  input  logic             NEXT,
  input  logic             MODE,
  input  logic             PAUSE,
  output logic [PAT_W-1:0] PAT_SEL,
  output logic             BLANK,
  output logic             PAT_CHG,
  output logic             AUTO,
  output logic [15:0]      FRAME_CNT
);

  localparam int unsigned HOLD_W  = cnt_w(HOLD_FRAMES);
  localparam int unsigned BLANK_W = cnt_w(STARTUP_FRAMES);

  state_e              state_q, state_d;
  logic [PAT_W-1:0]    pat_sel_q, pat_sel_d;
  logic                blank_q, blank_d;
  logic                pat_chg_q, pat_chg_d;
  logic                auto_q, auto_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [BLANK_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic                next_pend_q, next_pend_d;
  logic                mode_pend_q, mode_pend_d;

  logic                tick_c;
  logic                next_eff_c;
  logic                mode_eff_c;
  logic                blank_done_c;
  logic                expire_c;
  logic                adv_c;
  logic [PAT_W-1:0]    pat_inc_c;

  pattern_frame_tick #(.VS_POL(VS_POL)) u_tick (
    .clk    (CLK),
    .rst_n  (RST_N),
    .vsync  (VSYNC),
    .tick_c (tick_c)
  );

  // Requests arriving in the tick cycle itself take effect at that tick.
  assign next_eff_c   = next_pend_q | NEXT;
  assign mode_eff_c   = mode_pend_q ^ MODE;
  assign blank_done_c = (blank_cnt_q == BLANK_W'(STARTUP_FRAMES - 1));
  assign expire_c     = !PAUSE && (hold_q == HOLD_W'(HOLD_FRAMES - 1));
  assign pat_inc_c    = (pat_sel_q == PAT_W'(NUM_PAT - 1)) ? '0 : pat_sel_q + PAT_W'(1);

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_BLANK;
      pat_sel_q   <= '0;
      blank_q     <= 1'b1;
      pat_chg_q   <= 1'b0;
      auto_q      <= 1'b1;
      frame_cnt_q <= '0;
      hold_q      <= '0;
      blank_cnt_q <= '0;
      next_pend_q <= 1'b0;
      mode_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_sel_q   <= pat_sel_d;
      blank_q     <= blank_d;
      pat_chg_q   <= pat_chg_d;
      auto_q      <= auto_d;
      frame_cnt_q <= frame_cnt_d;
      hold_q      <= hold_d;
      blank_cnt_q <= blank_cnt_d;
      next_pend_q <= next_pend_d;
      mode_pend_q <= mode_pend_d;
    end
  end

  // Next-state: transitions only at frame boundaries.
  always_comb begin
    state_d = state_q;
    if (tick_c) begin
      case (state_q)
        ST_BLANK:  if (blank_done_c) state_d = (auto_q ^ mode_eff_c) ? ST_AUTO : ST_MANUAL;
        ST_AUTO:   if (mode_eff_c)   state_d = ST_MANUAL;
        ST_MANUAL: if (mode_eff_c)   state_d = ST_AUTO;
        default:                     state_d = ST_BLANK;
      endcase
    end
  end

  // Outputs, counters and request latches.
  always_comb begin
    pat_sel_d   = pat_sel_q;
    blank_d     = blank_q;
    pat_chg_d   = 1'b0;
    auto_d      = auto_q;
    frame_cnt_d = frame_cnt_q;
    hold_d      = hold_q;
    blank_cnt_d = blank_cnt_q;
    next_pend_d = (state_q == ST_BLANK) ? 1'b0 : next_eff_c;
    mode_pend_d = mode_eff_c;
    adv_c       = 1'b0;

    if (tick_c) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      next_pend_d = 1'b0;
      mode_pend_d = 1'b0;
      case (state_q)
        ST_BLANK: begin
          // MODE keeps accumulating across the blank frames until exit.
          mode_pend_d = mode_eff_c;
          if (blank_done_c) begin
            blank_d     = 1'b0;
            pat_chg_d   = 1'b1;
            auto_d      = auto_q ^ mode_eff_c;
            mode_pend_d = 1'b0;
            blank_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + BLANK_W'(1);
          end
        end
        ST_AUTO, ST_MANUAL: begin
          if (mode_eff_c) begin
            // Pending NEXT is applied in the new mode; hold timer restarts.
            auto_d = (state_q == ST_MANUAL);
            hold_d = '0;
            adv_c  = next_eff_c;
          end else if (state_q == ST_AUTO) begin
            adv_c = next_eff_c | expire_c;
            if (adv_c)       hold_d = '0;
            else if (!PAUSE) hold_d = hold_q + HOLD_W'(1);
          end else begin
            adv_c = next_eff_c;
          end
          if (adv_c) begin
            pat_sel_d = pat_inc_c;
            pat_chg_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PAT_SEL   = pat_sel_q;
  assign BLANK     = blank_q;
  assign PAT_CHG   = pat_chg_q;
  assign AUTO      = auto_q;
  assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_pattern_sched.sv
// Bench for pattern_sched: frame-by-frame vector table plus hand sequences for
// same-cycle requests and asynchronous reset. Frames are compressed to one
// cycle per line (V_TOTAL cycles per frame, VSYNC low for 2 lines).
module tb_pattern_sched;
  import pattern_pkg::*;

  localparam int FL       = V_TOTAL;
  localparam int VS_LINES = 2;

  logic        clk;
  logic        rst_n;
  logic        vsync;
  logic        nxt;
  logic        mde;
  logic        pause;
  logic [2:0]  pat_sel;
  logic        blank;
  logic        pat_chg;
  logic        auto_o;
  logic [15:0] frame_cnt;

  int pos;
  int n_chk;
  int n_fail;

  typedef struct {
    int   frames;
    int   nx;
    int   md;
    logic pause;
    int   pat;
    logic blank;
    logic au;
    logic chg;
    int   fcnt;
  } row_t;

  row_t tbl[$];

  pattern_sched #(
    .NUM_PAT       (8),
    .PAT_W         (3),
    .HOLD_FRAMES   (3),
    .STARTUP_FRAMES(4),
    .VS_POL        (1'b0)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .VSYNC    (vsync),
    .NEXT     (nxt),
    .MODE     (mde),
    .PAUSE    (pause),
    .PAT_SEL  (pat_sel),
    .BLANK    (blank),
    .PAT_CHG  (pat_chg),
    .AUTO     (auto_o),
    .FRAME_CNT(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (frame pos %0d)", name, got, exp, pos);
    end
  endtask

  task automatic expect_out(input string tag, input int pat, input logic bl,
                            input logic au, input logic chg, input int fc);
    check($sformatf("%s.pat_sel", tag),   32'(pat_sel),   32'(pat));
    check($sformatf("%s.blank", tag),     32'(blank),     32'(bl));
    check($sformatf("%s.auto", tag),      32'(auto_o),    32'(au));
    check($sformatf("%s.pat_chg", tag),   32'(pat_chg),   32'(chg));
    check($sformatf("%s.frame_cnt", tag), 32'(frame_cnt), 32'(fc));
  endtask

  // One clock: inputs change on the falling edge, outputs are read there too.
  task automatic cyc(input logic nx, input logic md);
    @(negedge clk);
    pos   = (pos + 1) % FL;
    vsync = (pos < VS_LINES) ? 1'b0 : 1'b1;
    nxt   = nx;
    mde   = md;
  endtask

  task automatic run_to(input int p);
    do cyc(1'b0, 1'b0); while (pos != p);
  endtask

  // Run n frames; requests are pulsed mid-way through the last one.
  task automatic run_frames(input int n, input int nx, input int md, input logic p);
    pause = p;
    for (int f = 0; f < n - 1; f++) run_to(1);
    run_to(100);
    repeat (md) begin cyc(1'b0, 1'b1); cyc(1'b0, 1'b0); end
    repeat (nx) begin cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); end
    run_to(1);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    pos    = 10;
    vsync  = 1'b1;
    nxt    = 1'b0;
    mde    = 1'b0;
    pause  = 1'b0;
    rst_n  = 1'b1;

    // frames, nx, md, pause -> pat, blank, auto, pat_chg, frame_cnt (after last tick)
    tbl.push_back('{3, 0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0,  3});  // startup blank
    tbl.push_back('{1, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1,  4});  // unblank
    tbl.push_back('{2, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0,  6});
    tbl.push_back('{1, 0, 0, 1'b0, 1, 1'b0, 1'b1, 1'b1,  7});
    tbl.push_back('{3, 0, 0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 10});
    tbl.push_back('{3, 0, 0, 1'b0, 3, 1'b0, 1'b1, 1'b1, 13});
    tbl.push_back('{3, 0, 0, 1'b0, 4, 1'b0, 1'b1, 1'b1, 16});
    tbl.push_back('{2, 0, 0, 1'b0, 4, 1'b0, 1'b1, 1'b0, 18});
    tbl.push_back('{1, 0, 0, 1'b0, 5, 1'b0, 1'b1, 1'b1, 19});
    tbl.push_back('{3, 0, 0, 1'b0, 6, 1'b0, 1'b1, 1'b1, 22});
    tbl.push_back('{3, 0, 0, 1'b0, 7, 1'b0, 1'b1, 1'b1, 25});
    tbl.push_back('{3, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 28});  // wrap
    tbl.push_back('{1, 0, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 29});  // to manual
    tbl.push_back('{1, 3, 0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 30});  // 3 NEXT -> +1
    tbl.push_back('{1, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 31});  // manual holds
    tbl.push_back('{1, 0, 2, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32});  // MODE x2 cancels
    // second part, after the same-cycle NEXT sequence
    tbl.push_back('{1, 0, 1, 1'b0, 3, 1'b0, 1'b1, 1'b0, 35});  // back to auto
    tbl.push_back('{2, 0, 0, 1'b0, 3, 1'b0, 1'b1, 1'b0, 37});  // hold at limit
    tbl.push_back('{4, 0, 0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 41});  // paused
    tbl.push_back('{1, 1, 0, 1'b1, 4, 1'b0, 1'b1, 1'b1, 42});  // NEXT while paused
    tbl.push_back('{5, 0, 0, 1'b1, 4, 1'b0, 1'b1, 1'b0, 47});
    tbl.push_back('{2, 0, 0, 1'b0, 4, 1'b0, 1'b1, 1'b0, 49});  // resumed
    tbl.push_back('{1, 0, 0, 1'b0, 5, 1'b0, 1'b1, 1'b1, 50});  // 3rd tick after resume

    #1 rst_n = 1'b0;
    #1 expect_out("reset", 0, 1'b1, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_frames(tbl[i].frames, tbl[i].nx, tbl[i].md, tbl[i].pause);
      expect_out($sformatf("row%0d", i), tbl[i].pat, tbl[i].blank, tbl[i].au,
                 tbl[i].chg, tbl[i].fcnt);
    end

    // NEXT coincident with tick applies there; NEXT one cycle later waits a frame.
    run_to(FL - 1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    expect_out("next_at_tick", 2, 1'b0, 1'b0, 1'b1, 33);
    cyc(1'b0, 1'b0);
    check("pat_chg_one_cycle", 32'(pat_chg), 32'd0);
    run_to(FL - 1);
    check("next_after_tick_waits", 32'(pat_sel), 32'd2);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    expect_out("next_after_tick", 3, 1'b0, 1'b0, 1'b1, 34);

    for (int i = 16; i < tbl.size(); i++) begin
      run_frames(tbl[i].frames, tbl[i].nx, tbl[i].md, tbl[i].pause);
      expect_out($sformatf("row%0d", i), tbl[i].pat, tbl[i].blank, tbl[i].au,
                 tbl[i].chg, tbl[i].fcnt);
    end

    // Asynchronous reset mid-frame, then the startup blank restarts.
    run_to(200);
    check("pre_reset_pat", 32'(pat_sel), 32'd5);
    rst_n = 1'b0;
    #1 expect_out("async_reset", 0, 1'b1, 1'b1, 1'b0, 0);
    repeat (4) cyc(1'b0, 1'b0);
    rst_n = 1'b1;
    run_frames(3, 2, 0, 1'b0);
    expect_out("reblank", 0, 1'b1, 1'b1, 1'b0, 3);
    run_to(FL - 1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    expect_out("reunblank", 0, 1'b0, 1'b1, 1'b1, 4);
    run_frames(1, 0, 0, 1'b0);
    expect_out("no_stale_next", 0, 1'b0, 1'b1, 1'b0, 5);
    run_frames(2, 0, 0, 1'b0);
    expect_out("auto_after_reset", 1, 1'b0, 1'b1, 1'b1, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
